// File: rtl/cmos_nvram_arbiter_pkg.sv
// Shared types for the Williams-2 CMOS RAM arbiter: port-owner states and latched operation.
package nvram_pkg;

   typedef enum logic [2:0] {
      ST_CPU,
      ST_HOLD,
      ST_XFER,
      ST_CLEAR,
      ST_RELEASE
   } state_e;

   typedef enum logic [1:0] {
      OP_DL,
      OP_UL,
      OP_CLR
   } op_e;

   localparam logic [15:0] NV_INDEX_DEF = 16'd4;

endpackage

// File: rtl/cmos_nvram_arbiter.sv
// Arbitrates the single-port CMOS RAM between the 6809 and the HPS ioctl channel;
// HPS save/restore and high-score clears run with the CPU halted via hold/ack.
module cmos_nvram_arbiter
   import nvram_pkg::*;
#(
   parameter int                ADDR_W    = 10,
   parameter int                DATA_W    = 4,
   parameter logic [15:0]       NV_INDEX  = NV_INDEX_DEF,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              cpu_ce,
   input  logic              cpu_cs,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic [DATA_W-1:0] cpu_dout,
   output logic              cpu_hold,
   input  logic              cpu_hold_ack,
   input  logic              ioctl_download,
   input  logic              ioctl_upload,
   input  logic [15:0]       ioctl_index,
   input  logic [24:0]       ioctl_addr,
   input  logic              ioctl_wr,
   input  logic              ioctl_rd,
   input  logic [7:0]        ioctl_dout,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   input  logic              clear_req,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              dirty
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic              dirty_q, dirty_d;
   logic              clr_pend_q, clr_pend_d;
   logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              wr_pend_q, wr_pend_d;
   logic [1:0]        rd_ph_q, rd_ph_d;
   logic              rd_oor_q, rd_oor_d;
   logic [7:0]        ioctl_din_q, ioctl_din_d;
   logic              rd_pend_q, rd_pend_d;
   logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;

   logic idx_ok, xfer_req, xfer_on, in_range, cpu_wr;
   logic unused_dout_hi;

   assign unused_dout_hi = ^ioctl_dout[7:DATA_W];

   assign idx_ok   = (ioctl_index == NV_INDEX);
   assign xfer_req = (ioctl_download | ioctl_upload) & idx_ok;
   assign xfer_on  = (op_q == OP_UL) ? ioctl_upload : ioctl_download;
   assign in_range = ((ioctl_addr >> ADDR_W) == '0);
   assign cpu_wr   = cpu_ce & cpu_cs & cpu_we;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dirty_d    = dirty_q;
      clr_pend_d = clr_pend_q;
      clr_cnt_d  = clr_cnt_q;
      unique case (state_q)
         ST_CPU: begin
            if (cpu_wr) dirty_d = 1'b1;
            // A transfer outranks any clear requested in the same cycle.
            if (xfer_req) begin
               state_d    = ST_HOLD;
               op_d       = ioctl_download ? OP_DL : OP_UL;
               clr_pend_d = 1'b0;
            end else if (clear_req || clr_pend_q) begin
               state_d    = ST_HOLD;
               op_d       = OP_CLR;
               clr_pend_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (cpu_hold_ack) begin
               state_d   = (op_q == OP_CLR) ? ST_CLEAR : ST_XFER;
               clr_cnt_d = '0;
            end
         end
         ST_XFER: begin
            if (!xfer_on) begin
               state_d = ST_RELEASE;
               if (op_q == OP_UL) dirty_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            // A transfer that arrived mid-clear takes the port without un-halting the CPU.
            if (clr_cnt_d[ADDR_W]) begin
               if (xfer_req) begin
                  state_d = ST_XFER;
                  op_d    = ioctl_download ? OP_DL : OP_UL;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            state_d = ST_CPU;
            if (clear_req) clr_pend_d = 1'b1;
         end
         default: state_d = ST_CPU;
      endcase
   end

   always_comb begin
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      wr_pend_d   = 1'b0;
      rd_ph_d     = rd_ph_q;
      rd_oor_d    = rd_oor_q;
      ioctl_din_d = ioctl_din_q;
      rd_pend_d   = (state_q == ST_CPU) & cpu_ce & cpu_cs & ~cpu_we;
      cpu_dout_d  = rd_pend_q ? ram_rdata : cpu_dout_q;
      if (state_q == ST_XFER && idx_ok) begin
         if (ioctl_wr) begin
            ram_addr_d  = ioctl_addr[ADDR_W-1:0];
            ram_wdata_d = ioctl_dout[DATA_W-1:0];
            wr_pend_d   = in_range;
         end else if (ioctl_rd && rd_ph_q == 2'd0) begin
            ram_addr_d = ioctl_addr[ADDR_W-1:0];
            rd_oor_d   = ~in_range;
            rd_ph_d    = 2'd1;
         end
      end
      // Phase 1: RAM samples the address; phase 2: read data is on ram_rdata.
      if (rd_ph_q == 2'd1) begin
         rd_ph_d = 2'd2;
      end else if (rd_ph_q == 2'd2) begin
         rd_ph_d     = 2'd0;
         ioctl_din_d = rd_oor_q ? 8'h00 : 8'(ram_rdata);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_CPU;
         op_q        <= OP_DL;
         dirty_q     <= 1'b0;
         clr_pend_q  <= 1'b0;
         clr_cnt_q   <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         wr_pend_q   <= 1'b0;
         rd_ph_q     <= 2'd0;
         rd_oor_q    <= 1'b0;
         ioctl_din_q <= 8'h00;
         rd_pend_q   <= 1'b0;
         cpu_dout_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         dirty_q     <= dirty_d;
         clr_pend_q  <= clr_pend_d;
         clr_cnt_q   <= clr_cnt_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         wr_pend_q   <= wr_pend_d;
         rd_ph_q     <= rd_ph_d;
         rd_oor_q    <= rd_oor_d;
         ioctl_din_q <= ioctl_din_d;
         rd_pend_q   <= rd_pend_d;
         cpu_dout_q  <= cpu_dout_d;
      end
   end

   always_comb begin
      ram_addr  = ram_addr_q;
      ram_we    = wr_pend_q;
      ram_wdata = ram_wdata_q;
      unique case (state_q)
         ST_CPU: begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_wr;
            ram_wdata = cpu_din;
         end
         ST_CLEAR: begin
            ram_addr  = clr_cnt_q[ADDR_W-1:0];
            ram_we    = ~clr_cnt_q[ADDR_W];
            ram_wdata = CLEAR_VAL;
         end
         default: ;
      endcase
   end

   assign cpu_hold   = (state_q == ST_HOLD) | (state_q == ST_XFER) | (state_q == ST_CLEAR);
   assign busy       = (state_q != ST_CPU);
   assign dirty      = dirty_q;
   assign cpu_dout   = cpu_dout_q;
   assign ioctl_din  = ioctl_din_q;
   // HPS is stalled for a pending NVRAM transfer until the port is ours, and during reads.
   assign ioctl_wait = (rd_ph_q != 2'd0) | (xfer_req & (state_q != ST_XFER));

endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
// Scoreboard bench for cmos_nvram_arbiter: directed CPU, download, upload, clear,
// clear/transfer conflict and mid-download reset scenarios against a behavioural RAM.
module tb_cmos_nvram_arbiter;

   logic        clk_sys, reset_n;
   logic        cpu_ce, cpu_cs, cpu_we;
   logic [9:0]  cpu_addr;
   logic [3:0]  cpu_din, cpu_dout;
   logic        cpu_hold, cpu_hold_ack;
   logic        ioctl_download, ioctl_upload;
   logic [15:0] ioctl_index;
   logic [24:0] ioctl_addr;
   logic        ioctl_wr, ioctl_rd;
   logic [7:0]  ioctl_dout, ioctl_din;
   logic        ioctl_wait, clear_req;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [3:0]  ram_wdata, ram_rdata;
   logic        busy, dirty;

   logic [3:0]  mem [1024];
   logic        mem_fill;
   logic [3:0]  fill_val;

   int errors, checks, we_cnt;
   logic [7:0] q_cpu[$];
   logic [7:0] q_ul[$];

   cmos_nvram_arbiter dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cpu_ce(cpu_ce), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_hold(cpu_hold), .cpu_hold_ack(cpu_hold_ack),
      .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_addr(ioctl_addr), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_dout(ioctl_dout),
      .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .clear_req(clear_req),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy), .dirty(dirty)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   // Behavioural single-port RAM, one-cycle read latency.
   always @(posedge clk_sys) begin
      if (mem_fill) begin
         for (int i = 0; i < 1024; i++) mem[i] <= fill_val;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   // CPU halt model: acknowledges after cpu_hold has been high for 5 cycles.
   initial begin
      logic [4:0] hist;
      hist = '0;
      cpu_hold_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         hist = cpu_hold ? {hist[3:0], 1'b1} : 5'b0;
         cpu_hold_ack = hist[4];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops expected read data when the DUT presents it.
   initial begin
      logic cpu_arm, ul_arm;
      cpu_arm = 1'b0;
      ul_arm  = 1'b0;
      we_cnt  = 0;
      forever begin
         @(posedge clk_sys);
         #1;
         if (ram_we) we_cnt++;
         if (!reset_n) begin
            cpu_arm = 1'b0;
            ul_arm  = 1'b0;
         end else begin
            if (cpu_arm) begin
               if (q_cpu.size() == 0) chk("cpu_dout_unexpected", 32'(cpu_dout), 32'hFFFF);
               else chk("cpu_dout", 32'(cpu_dout), 32'(q_cpu.pop_front()));
            end
            cpu_arm = cpu_ce & cpu_cs & ~cpu_we;
            if (ul_arm && !ioctl_wait) begin
               if (q_ul.size() == 0) chk("ioctl_din_unexpected", 32'(ioctl_din), 32'hFFFF);
               else chk("ioctl_din", 32'(ioctl_din), 32'(q_ul.pop_front()));
               ul_arm = 1'b0;
            end
            if (ioctl_rd) ul_arm = 1'b1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk_sys);
   endtask

   task automatic cpu_wr(input logic [9:0] a, input logic [3:0] d);
      cpu_ce = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
      #1 chk("cpu_ram_we", 32'(ram_we), 32'd1);
      tick();
      cpu_ce = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic cpu_rd(input logic [9:0] a, input logic [3:0] exp);
      cpu_ce = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      q_cpu.push_back({4'h0, exp});
      tick();
      cpu_ce = 1'b0;
      repeat (2) tick();
   endtask

   task automatic wait_ready();
      int c;
      c = 0;
      while (ioctl_wait && c < 3000) begin
         tick();
         c++;
      end
      if (c >= 3000) chk("wait_timeout", 32'(ioctl_wait), 32'd0);
   endtask

   task automatic ul_rd(input int a, input logic [7:0] exp, output int wcyc);
      ioctl_rd = 1'b1; ioctl_addr = 25'(a);
      q_ul.push_back(exp);
      tick();
      ioctl_rd = 1'b0;
      wcyc = 0;
      while (ioctl_wait && wcyc < 10) begin
         wcyc++;
         tick();
      end
   endtask

   initial begin
      int bad, c, w0, drop;
      errors = 0; checks = 0;
      reset_n = 1'b0;
      cpu_ce = 0; cpu_cs = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
      ioctl_download = 0; ioctl_upload = 0; ioctl_index = '0; ioctl_addr = '0;
      ioctl_wr = 0; ioctl_rd = 0; ioctl_dout = '0; clear_req = 0;
      mem_fill = 1'b1; fill_val = 4'h0;
      repeat (3) tick();
      mem_fill = 1'b0;
      chk("rst_hold", 32'(cpu_hold), 0);
      chk("rst_wait", 32'(ioctl_wait), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dirty", 32'(dirty), 0);
      chk("rst_din", 32'(ioctl_din), 0);
      chk("rst_cpu_dout", 32'(cpu_dout), 0);
      chk("rst_ram_addr_wdata", 32'({ram_addr, ram_wdata}), 0);
      reset_n = 1'b1;
      tick();

      // CPU write then read back
      w0 = we_cnt;
      cpu_wr(10'h155, 4'hA);
      chk("cpu_dirty", 32'(dirty), 1);
      tick();
      chk("cpu_we_pulses", 32'(we_cnt - w0), 1);
      cpu_rd(10'h155, 4'hA);

      // Strobes for a foreign index are ignored
      ioctl_index = 16'd5; ioctl_download = 1'b1; w0 = we_cnt;
      for (int i = 0; i < 4; i++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'hEE;
         tick();
      end
      ioctl_wr = 1'b0;
      tick();
      chk("foreign_busy", 32'(busy), 0);
      chk("foreign_wait", 32'(ioctl_wait), 0);
      chk("foreign_writes", 32'(we_cnt - w0), 0);
      ioctl_download = 1'b0;
      tick();

      // Full download, pattern n[7:0]
      ioctl_index = 16'd4; ioctl_download = 1'b1;
      tick();
      chk("dl_hold_rise", 32'(cpu_hold), 1);
      chk("dl_stall", 32'(ioctl_wait), 1);
      wait_ready();
      w0 = we_cnt; bad = 0;
      for (int n = 0; n < 1024; n++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(n); ioctl_dout = 8'(n);
         tick();
         if (ioctl_wait) bad++;
      end
      ioctl_addr = 25'd1024; ioctl_dout = 8'h07;
      tick();
      ioctl_wr = 1'b0;
      tick();
      chk("dl_wait_low", 32'(bad), 0);
      chk("dl_writes", 32'(we_cnt - w0), 1024);
      ioctl_download = 1'b0;
      tick();
      chk("dl_hold_fall", 32'(cpu_hold), 0);
      tick();
      chk("dl_busy_end", 32'(busy), 0);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== 4'(i)) bad++;
      chk("dl_ram", 32'(bad), 0);
      chk("dl_dirty_kept", 32'(dirty), 1);

      // Full upload
      ioctl_upload = 1'b1;
      tick();
      chk("ul_hold_rise", 32'(cpu_hold), 1);
      wait_ready();
      bad = 0;
      for (int n = 0; n < 1024; n++) begin
         ul_rd(n, {4'h0, 4'(n)}, c);
         if (c != 2) bad++;
      end
      ul_rd(1029, 8'h00, c);
      chk("ul_wait_2cyc", 32'(bad), 0);
      ioctl_upload = 1'b0;
      repeat (2) tick();
      chk("ul_dirty_clr", 32'(dirty), 0);
      chk("ul_busy_end", 32'(busy), 0);

      // Clear over a RAM full of 4'hF
      cpu_wr(10'h007, 4'h3);
      mem_fill = 1'b1; fill_val = 4'hF;
      tick();
      mem_fill = 1'b0;
      w0 = we_cnt;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      chk("clr_hold_rise", 32'(cpu_hold), 1);
      c = 0;
      while (busy && c < 3000) begin
         c++;
         tick();
      end
      chk("clr_busy_cycles", 32'(c), 1030);
      chk("clr_writes", 32'(we_cnt - w0), 1024);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== 4'h0) bad++;
      chk("clr_ram", 32'(bad), 0);
      chk("clr_dirty_kept", 32'(dirty), 1);

      // Download requested mid-clear, clear_req mid-transfer
      mem_fill = 1'b1; fill_val = 4'hF;
      tick();
      mem_fill = 1'b0;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      c = 0;
      while (!(busy && ram_we && ram_addr == 10'd300) && c < 3000) begin
         c++;
         tick();
      end
      ioctl_index = 16'd4; ioctl_download = 1'b1; drop = 0;
      tick();
      c = 0;
      while (ioctl_wait && c < 3000) begin
         if (!cpu_hold) drop++;
         c++;
         tick();
      end
      chk("cx_wait_cycles", 32'(c), 723);
      w0 = we_cnt;
      for (int i = 0; i < 16; i++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(256 + i); ioctl_dout = 8'(8'h30 + i);
         clear_req = (i == 8);
         if (!cpu_hold) drop++;
         tick();
      end
      ioctl_wr = 1'b0; clear_req = 1'b0;
      tick();
      chk("cx_writes", 32'(we_cnt - w0), 16);
      chk("cx_no_hold_drop", 32'(drop), 0);
      ioctl_download = 1'b0;
      repeat (4) tick();
      chk("cx_busy_end", 32'(busy), 0);
      bad = 0;
      for (int i = 0; i < 1024; i++)
         if (mem[i] !== ((i >= 256 && i < 272) ? 4'(i - 256) : 4'h0)) bad++;
      chk("cx_ram", 32'(bad), 0);

      // Reset mid-download at byte 500
      ioctl_download = 1'b1;
      tick();
      wait_ready();
      for (int n = 0; n < 500; n++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(n); ioctl_dout = 8'(n);
         tick();
      end
      reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      #1;
      chk("rr_hold", 32'(cpu_hold), 0);
      chk("rr_busy", 32'(busy), 0);
      chk("rr_dirty", 32'(dirty), 0);
      tick();
      reset_n = 1'b1;
      tick();
      cpu_wr(10'h3FF, 4'h6);
      chk("rr_dirty_set", 32'(dirty), 1);
      tick();
      cpu_rd(10'h3FF, 4'h6);
      cpu_rd(10'h0AB, 4'hB);

      repeat (4) tick();
      chk("sb_cpu_drained", 32'(q_cpu.size()), 0);
      chk("sb_ul_drained", 32'(q_ul.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
